pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h01000000, meaning PC value loaded on reset.
REQ-003 SHALL have parameter TRAP_VECTOR, default 32'h00000100, meaning PC value loaded on trap or misaligned redirect.
REQ-004 SHALL have parameter INSTR_BYTES, default 4 (power of 2), meaning sequential increment and alignment granule.
REQ-005 SHALL have parameter RAS_DEPTH, default 4 (power of 2, at least 2), meaning return-address-stack entries.
REQ-006 SHALL have the following ports, one per line as name, direction, width, meaning; one clock; reset is synchronous and active-high:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- fetch_ready  in  1  fetch accepts pc_out this cycle.
- stall  in  1  blocks sequential advance.
- trap  in  1  trap request.
- br_taken  in  1  branch redirect.
- br_target  in  XLEN  branch destination.
- jmp  in  1  jump redirect.
- call  in  1  jump that pushes a return address.
- ret  in  1  return redirect.
- jmp_target  in  XLEN  destination for jmp/call; fallback for ret.
- pc_out  out  XLEN  current PC.
- pc_valid  out  1  pc_out is presentable to fetch.
- misalign  out  1  one-cycle pulse: misaligned redirect was trapped.
- ras_empty  out  1  return-address stack holds no entries.

Function
REQ-007 SHALL fire a transfer on a cycle where pc_valid and fetch_ready are both 1.
REQ-008 SHALL resolve next-PC by priority: trap > br_taken > ret > call/jmp > sequential > hold.
REQ-009 SHALL compute sequential next-PC as pc_out+INSTR_BYTES modulo 2^XLEN, taken only on a transfer with stall=0; wrap from all-ones region to 0 is legal, with no flag.
REQ-010 SHALL apply trap and redirects on the next edge regardless of fetch_ready or stall; pc_valid stays 1.
REQ-011 SHALL, when the selected redirect target has nonzero low log2(INSTR_BYTES) bits, load TRAP_VECTOR instead and assert misalign for exactly one cycle.
REQ-012 SHALL treat trap as never misaligned, and SHALL leave the stack unchanged on trap.
REQ-013 SHALL hold pc_out unchanged when no transfer fires and no redirect is present.
REQ-014 SHALL, with PC_GEN_RAS_EN defined, on call push pc_out+INSTR_BYTES and load jmp_target.
REQ-015 SHALL, with PC_GEN_RAS_EN defined, on ret with stack non-empty pop and load the popped address; with stack empty, load jmp_target.
REQ-016 SHALL, when the stack is full, make a push overwrite the oldest entry (circular), leaving depth at RAS_DEPTH.
REQ-017 SHALL give call and ret asserted together ret priority for the PC, with the stack performing pop-then-push (top replaced, depth unchanged; on empty, push only).
REQ-018 SHALL leave the stack unchanged for call/ret that lose priority to trap or br_taken.

Reset
REQ-019 SHALL, on rst=1 at an edge, set pc_out=RESET_VECTOR, pc_valid=0, misalign=0, stack depth=0 and ras_empty=1; rst overrides all inputs.
REQ-020 SHALL drive pc_valid=1 from the first edge with rst=0, with pc_out still RESET_VECTOR.
REQ-021 SHALL discard any in-flight redirect or stack operation when rst is asserted mid-operation.

Configuration
REQ-022 SHALL, with PC_GEN_RAS_EN defined, instantiate the return-address stack per REQ-014..018.
REQ-023 SHALL, without PC_GEN_RAS_EN, treat call and ret as jmp to jmp_target, tie ras_empty=1, build no stack storage and keep the port list identical.

Structure
REQ-024 SHALL keep in shared package pc_pkg: XLEN default, RESET_VECTOR and TRAP_VECTOR constants, and the next-PC-source enum (SRC_HOLD, SRC_SEQ, SRC_JMP, SRC_RET, SRC_BR, SRC_TRAP).
REQ-025 SHALL place the stack in sub-module pc_ras (push, pop, top, empty, full), instantiated only under PC_GEN_RAS_EN.

Verification
REQ-026 Reset: rst=1 one edge -> pc_out=32'h01000000, pc_valid=0; release -> pc_valid=1, same pc.
REQ-027 Sequential/stall: fetch_ready=1 for 3 cycles -> 01000004, 01000008, 0100000C; stall=1 -> holds; fetch_ready=0 -> holds.
REQ-028 Priority/misalign: trap with br_taken (br_target=32'h200) -> pc=00000100; br_target=32'h202 alone -> pc=00000100, misalign pulses 1 cycle.
REQ-029 Wrap: pc=32'hFFFFFFFC, transfer -> pc=0, misalign=0.
REQ-030 RAS (macro on): call at pc=1000, jmp_target=2000 -> pc=2000; ret -> pc=1004, ras_empty=1; 5 calls, then 5 rets -> 4 correct returns, 5th uses jmp_target.
REQ-031 Macro off: call/ret -> behave as jmp to jmp_target; ras_empty stays 1.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared PC generator constants and next-PC source encoding.
package pc_pkg;
    localparam int          PC_XLEN         = 32;
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0100_0000;
    localparam logic [31:0] PC_TRAP_VECTOR  = 32'h0000_0100;
    typedef enum logic [2:0] {
        SRC_HOLD,
        SRC_SEQ,
        SRC_JMP,
        SRC_RET,
        SRC_BR,
        SRC_TRAP
    } pc_src_e;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [PW:0]      r_cnt;
    logic [PW-1:0]    w_top_idx;
    assign w_top_idx = r_ptr - 1'b1;
    assign top   = r_mem[w_top_idx];
    assign empty = r_cnt == '0;
    assign full  = r_cnt == (PW+1)'(DEPTH);
    // pop+push on a non-empty stack rewrites the top in place
    always_ff @(posedge clk) begin
        if (!rst && push)
            r_mem[(pop && !empty) ? w_top_idx : r_ptr] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (push && !(pop && !empty)) begin
            r_ptr <= r_ptr + 1'b1;
            r_cnt <= full ? r_cnt : r_cnt + 1'b1;
        end else if (pop && !push && !empty) begin
            r_ptr <= w_top_idx;
            r_cnt <= r_cnt - 1'b1;
        end
    end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: program counter with prioritized redirects and misalign trapping.
// Define PC_GEN_RAS_EN to build the return-address stack; otherwise call/ret act as jmp.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN         = PC_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(PC_TRAP_VECTOR),
    parameter int              INSTR_BYTES  = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic            trap,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jmp,
    input  logic            call,
    input  logic            ret,
    input  logic [XLEN-1:0] jmp_target,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_valid,
    output logic            misalign,
    output logic            ras_empty
);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0 ||
        INSTR_BYTES < 1 || (INSTR_BYTES & (INSTR_BYTES - 1)) != 0) begin : g_bad_param
        $error("pc_gen: RAS_DEPTH and INSTR_BYTES must be powers of two");
    end
    logic [XLEN-1:0] r_pc;
    logic            r_valid, r_mis;
    pc_src_e         w_src;
    logic [XLEN-1:0] w_seq, w_ras_top, w_ret_tgt, w_redir_tgt, w_next;
    logic            w_ras_empty, w_redir, w_mis;
    assign w_seq       = r_pc + XLEN'(INSTR_BYTES);
    assign w_src       = trap ? SRC_TRAP :
                         br_taken ? SRC_BR :
                         ret ? SRC_RET :
                         (call || jmp) ? SRC_JMP :
                         (r_valid && fetch_ready && !stall) ? SRC_SEQ : SRC_HOLD;
    assign w_ret_tgt   = w_ras_empty ? jmp_target : w_ras_top;
    assign w_redir_tgt = (w_src == SRC_BR) ? br_target : (w_src == SRC_RET) ? w_ret_tgt : jmp_target;
    assign w_redir     = w_src inside {SRC_BR, SRC_RET, SRC_JMP};
    assign w_mis       = w_redir && |(w_redir_tgt & ALIGN_MASK);
    assign w_next      = (w_src == SRC_TRAP || w_mis) ? TRAP_VECTOR :
                         w_redir ? w_redir_tgt :
                         (w_src == SRC_SEQ) ? w_seq : r_pc;
`ifdef PC_GEN_RAS_EN
    logic w_push, w_pop, w_unused_full;
    // stack only moves when call/ret actually won the PC arbitration
    assign w_push = call && (w_src == SRC_RET || w_src == SRC_JMP);
    assign w_pop  = (w_src == SRC_RET) && !w_ras_empty;
    pc_ras #(.WIDTH(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_seq),
        .top   (w_ras_top),
        .empty (w_ras_empty),
        .full  (w_unused_full)
    );
`else
    assign w_ras_empty = 1'b1;
    assign w_ras_top   = w_seq;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_VECTOR;
            r_valid <= 1'b0;
            r_mis   <= 1'b0;
        end else begin
            r_pc    <= w_next;
            r_valid <= 1'b1;
            r_mis   <= w_mis;
        end
    end
    assign pc_out    = r_pc;
    assign pc_valid  = r_valid;
    assign misalign  = r_mis;
    assign ras_empty = w_ras_empty;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: randomized scoreboard bench for pc_gen against a queue-based reference model.
// Model follows PC_GEN_RAS_EN the same way the design build does.
module tb_pc_gen;
    localparam logic [31:0] RV = 32'h0100_0000;
    localparam logic [31:0] TV = 32'h0000_0100;
    logic        clk = 1'b0;
    logic        rst, fetch_ready, stall, trap, br_taken, jmp, call, ret;
    logic [31:0] br_target, jmp_target, pc_out;
    logic        pc_valid, misalign, ras_empty;
    typedef struct {
        logic [31:0] pc;
        logic        v;
        logic        m;
        logic        e;
        string       nm;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] m_stk[$];
    logic [31:0] m_pc;
    logic        m_v, m_m;
    int          errors = 0;
    int          checks = 0;

    pc_gen dut (
        .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .stall(stall), .trap(trap),
        .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .call(call), .ret(ret),
        .jmp_target(jmp_target), .pc_out(pc_out), .pc_valid(pc_valid),
        .misalign(misalign), .ras_empty(ras_empty)
    );

    always #5 clk = ~clk;

    task automatic m_push(input logic [31:0] a);
        if (m_stk.size() == 4) void'(m_stk.pop_front());
        m_stk.push_back(a);
    endtask

    task automatic cyc(input string nm, input logic r, fr, st, tp, br, input logic [31:0] bt,
                       input logic jp, cl, rt, input logic [31:0] jt);
        logic [31:0] old, t;
        logic        red;
        @(negedge clk);
        rst = r; fetch_ready = fr; stall = st; trap = tp; br_taken = br;
        br_target = bt; jmp = jp; call = cl; ret = rt; jmp_target = jt;
        old = m_pc; t = jt; red = 1'b0;
        if (r) begin
            m_pc = RV; m_v = 1'b0; m_m = 1'b0; m_stk.delete();
        end else begin
            m_m = 1'b0;
            if (tp) m_pc = TV;
            else if (br) begin t = bt; red = 1'b1; end
            else if (rt) begin
                red = 1'b1;
`ifdef PC_GEN_RAS_EN
                if (m_stk.size() > 0) t = m_stk.pop_back();
                if (cl) m_push(old + 32'd4);
`endif
            end else if (jp || cl) begin
                red = 1'b1;
`ifdef PC_GEN_RAS_EN
                if (cl) m_push(old + 32'd4);
`endif
            end else if (m_v && fr && !st) m_pc = old + 32'd4;
            if (red) begin
                if (t[1:0] != 2'b00) begin m_pc = TV; m_m = 1'b1; end
                else m_pc = t;
            end
            m_v = 1'b1;
        end
        exp_q.push_back('{m_pc, m_v, m_m, m_stk.size() == 0, nm});
    endtask

    task automatic idle(input string nm, input logic fr, st);
        cyc(nm, 1'b0, fr, st, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic jump(input string nm, input logic cl, rt, input logic [31:0] jt);
        cyc(nm, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, !(cl || rt), cl, rt, jt);
    endtask

    // monitor: one output sample per cycle, away from the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (pc_out !== e.pc || pc_valid !== e.v || misalign !== e.m || ras_empty !== e.e) begin
                    errors++;
                    $display("FAIL %s: got pc=%h valid=%b mis=%b empty=%b, expected pc=%h valid=%b mis=%b empty=%b",
                             e.nm, pc_out, pc_valid, misalign, ras_empty, e.pc, e.v, e.m, e.e);
                end
            end
        end
    end

    initial begin
        logic [31:0] bt, jt;
        m_pc = RV; m_v = 1'b0; m_m = 1'b0;
        cyc("reset", 1, 1, 0, 1, 1, 32'h200, 1, 1, 1, 32'h3000);
        cyc("reset2", 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        idle("release", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle("seq", 1'b1, 1'b0);
        idle("stall_hold", 1'b1, 1'b1);
        idle("notready_hold", 1'b0, 1'b0);
        cyc("trap_over_br", 0, 0, 1, 1, 1, 32'h200, 0, 0, 0, 32'h0);
        cyc("br_misalign", 0, 0, 1, 0, 1, 32'h202, 0, 0, 0, 32'h0);
        idle("mis_clear", 1'b0, 1'b0);
        jump("jmp_top", 1'b0, 1'b0, 32'hFFFF_FFFC);
        idle("wrap", 1'b1, 1'b0);
        jump("jmp_1000", 1'b0, 1'b0, 32'h1000);
        jump("call_2000", 1'b1, 1'b0, 32'h2000);
        jump("ret_1004", 1'b0, 1'b1, 32'h3000);
        for (int i = 0; i < 5; i++) jump("call_n", 1'b1, 1'b0, 32'h4000 + 32'(i) * 32'h10);
        for (int i = 0; i < 5; i++) jump("ret_n", 1'b0, 1'b1, 32'h7000);
        jump("call_a", 1'b1, 1'b0, 32'h5000);
        jump("call_ret", 1'b1, 1'b1, 32'h6000);
        jump("ret_after", 1'b0, 1'b1, 32'h6100);
        cyc("trap_call", 0, 1, 0, 1, 0, 32'h0, 0, 1, 0, 32'h8000);
        cyc("br_ret", 0, 1, 0, 0, 1, 32'h9000, 0, 0, 1, 32'h8000);
        jump("call_mid", 1'b1, 1'b0, 32'hA000);
        cyc("rst_mid", 1, 1, 0, 0, 0, 32'h0, 0, 1, 0, 32'hB000);
        idle("post_rst", 1'b1, 1'b0);
        for (int i = 0; i < 400; i++) begin
            bt = $urandom; jt = $urandom;
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
            cyc("random", $urandom_range(0, 49) == 0, 1'($urandom), $urandom_range(0, 3) == 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, bt,
                $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, jt);
        end
        idle("drain", 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
